// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: framed byte stream -> big-endian 32-bit word writes.
// Optional checksum byte enabled with `define LOADER_CHECKSUM_EN.
module imem_program_loader #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] HEADER    = 8'hA5,
  parameter int         BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imu_wen,
  output logic [ADDR_W-1:0] imu_addr,
  output logic [31:0]       imu_data,
  output logic              cpu_clr,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-2:0] words_loaded
);

  localparam int WL_W      = ADDR_W - 1;
  localparam int MAX_WORDS = (2 ** ADDR_W) / 4;
  // Largest count whose last word still fits below the top of memory
  localparam int MAX_N     = MAX_WORDS - BASE_ADDR / 4;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd6;
`endif

  logic [2:0]        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [WL_W-1:0]   count_q, count_d;
  logic [WL_W-1:0]   wl_q, wl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [23:0]       word_q, word_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic accept;
  logic n_ok;

  assign byte_ready   = (state_q != S_WRITE);
  assign accept       = byte_valid & byte_ready;
  assign n_ok         = (byte_data != 8'd0) && (32'(byte_data) <= 32'(MAX_N));

  assign imu_wen      = (state_q == S_WRITE);
  assign imu_addr     = addr_q;
  assign imu_data     = data_q;
  assign cpu_clr      = (state_q != S_DONE);
  assign load_done    = (state_q == S_DONE);
  assign load_err     = (state_q == S_ERR);
  assign words_loaded = wl_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    wl_d    = wl_q;
    addr_d  = addr_q;
    data_d  = data_q;
    word_d  = word_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept && byte_data == HEADER) begin
          state_d = S_COUNT;
          wl_d    = '0;
        end
      end
      S_COUNT: begin
        if (accept) begin
          if (n_ok) begin
            count_d = WL_W'(byte_data);
            idx_d   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = 8'd0;
`endif
            state_d = S_DATA;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + byte_data;
`endif
          if (idx_q == 2'd3) begin
            // Address and data are registered here so they hold steady through WRITE
            data_d  = {word_q, byte_data};
            addr_d  = BASE + ADDR_W'({wl_q, 2'b00});
            idx_d   = 2'd0;
            state_d = S_WRITE;
          end else begin
            word_d = {word_q[15:0], byte_data};
            idx_d  = idx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        wl_d = wl_q + 1'b1;
        if (wl_d == count_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          state_d = (byte_data == sum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      count_q <= '0;
      wl_q    <= '0;
      addr_q  <= BASE;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      wl_q    <= wl_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Partial word and checksum are fully rebuilt each frame, so they need no reset
  always_ff @(posedge clk) begin
    word_q <= word_d;
`ifdef LOADER_CHECKSUM_EN
    sum_q  <= sum_d;
`endif
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: frames built from the framing rules,
// expected writes and flags derived from the frame contents.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        imu_wen;
  logic [7:0]  imu_addr;
  logic [31:0] imu_data;
  logic        cpu_clr;
  logic        load_done;
  logic        load_err;
  logic [6:0]  words_loaded;

  int total = 0;
  int bad = 0;

  logic [7:0]  tx[$];
  logic [39:0] exp_w[$];
  logic [39:0] cap[$];
  logic        exp_done, exp_err;
  int          exp_wl;

  imem_program_loader #(.ADDR_W(8), .HEADER(8'hA5), .BASE_ADDR(0)) dut (
    .clk(clk), .clr_n(clr_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imu_wen(imu_wen), .imu_addr(imu_addr), .imu_data(imu_data),
    .cpu_clr(cpu_clr), .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imu_wen === 1'b1) cap.push_back({imu_addr, imu_data});
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 8; k++) begin
      if (byte_ready === 1'b1) break;
      @(negedge clk);
    end
    if (byte_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout: byte_ready=%b required 1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic play(input bit gaps);
    cap.delete();
    foreach (tx[i]) send_byte(tx[i], gaps);
    repeat (3) @(negedge clk);
  endtask

  // Build a frame of n random words; invalid counts produce just HEADER+count
  task automatic build_frame(input int n, input bit good_sum);
    logic [7:0] s;
    logic [31:0] w;
    tx.delete(); exp_w.delete();
    s = 8'd0;
    tx.push_back(8'hA5);
    tx.push_back(8'(n));
    if (n < 1 || n > 64) begin
      exp_done = 0; exp_err = 1; exp_wl = 0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_w.push_back({8'(4 * i), w});
      for (int j = 3; j >= 0; j--) begin
        tx.push_back(w[8*j +: 8]);
        s = s + w[8*j +: 8];
      end
    end
    exp_wl = n;
`ifdef LOADER_CHECKSUM_EN
    tx.push_back(good_sum ? s : s ^ 8'(1 + $urandom_range(0, 254)));
    exp_done = good_sum; exp_err = !good_sum;
`else
    exp_done = 1; exp_err = 0;
`endif
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    #1;
    total++;
    if ({byte_ready, cpu_clr, imu_wen, load_done, load_err, words_loaded, imu_addr, imu_data} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 8'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset: rdy=%b clr=%b wen=%b done=%b err=%b wl=%0d addr=%0h data=%0h required 1 1 0 0 0 0 0 0",
               byte_ready, cpu_clr, imu_wen, load_done, load_err, words_loaded, imu_addr, imu_data);
    end
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    tx = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
`ifdef LOADER_CHECKSUM_EN
    tx.push_back(8'hA7);
`endif
    exp_w = '{{8'h00, 32'h20080005}, {8'h04, 32'h01095020}};
    play(0);
    total++;
    if (cap.size() != 2) begin
      bad++; $display("FAIL good_nwrites: got %0d required 2", cap.size());
    end
    for (int i = 0; i < cap.size() && i < 2; i++) begin
      total++;
      if (cap[i] !== exp_w[i]) begin
        bad++; $display("FAIL good_write%0d: got %h required %h", i, cap[i], exp_w[i]);
      end
    end
    total++;
    if ({load_done, load_err, cpu_clr, words_loaded} !== {1'b1, 1'b0, 1'b0, 7'd2}) begin
      bad++;
      $display("FAIL good_flags: done=%b err=%b clr=%b wl=%0d required 1 0 0 2",
               load_done, load_err, cpu_clr, words_loaded);
    end
  endtask

  task automatic test_bad_checksum();
`ifdef LOADER_CHECKSUM_EN
    tx = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h00};
    play(0);
    total++;
    if (cap.size() != 2 || cap[0] !== {8'h00, 32'h20080005} || cap[1] !== {8'h04, 32'h01095020}) begin
      bad++; $display("FAIL badsum_writes: got %0d writes required 2 matching writes", cap.size());
    end
    total++;
    if ({load_done, load_err, cpu_clr} !== 3'b011) begin
      bad++; $display("FAIL badsum_flags: done=%b err=%b clr=%b required 0 1 1", load_done, load_err, cpu_clr);
    end
`endif
  endtask

  task automatic test_count_limits();
    int counts[3] = '{0, 65, 64};
    foreach (counts[c]) begin
      build_frame(counts[c], 1);
      play(0);
      total++;
      if (cap.size() != exp_w.size()) begin
        bad++; $display("FAIL limit%0d_nwrites: got %0d required %0d", counts[c], cap.size(), exp_w.size());
      end else begin
        foreach (cap[i]) begin
          total++;
          if (cap[i] !== exp_w[i]) begin
            bad++; $display("FAIL limit%0d_write%0d: got %h required %h", counts[c], i, cap[i], exp_w[i]);
          end
        end
      end
      total++;
      if ({load_done, load_err, cpu_clr, words_loaded} !== {exp_done, exp_err, !exp_done, 7'(exp_wl)}) begin
        bad++;
        $display("FAIL limit%0d_flags: done=%b err=%b clr=%b wl=%0d required %b %b %b %0d", counts[c],
                 load_done, load_err, cpu_clr, words_loaded, exp_done, exp_err, !exp_done, exp_wl);
      end
    end
    total++;
    if (cap.size() == 0 || cap[cap.size()-1][39:32] !== 8'hFC) begin
      bad++; $display("FAIL limit64_lastaddr: got %0d writes, required last at addr fc", cap.size());
    end
  endtask

  task automatic test_idle_ignore_and_reload();
    // After DONE: a stray byte is ignored, then a header drops load_done next cycle
    build_frame(3, 1);
    play(0);
    cap.delete();
    send_byte(8'h33, 0);
    repeat (2) @(negedge clk);
    total++;
    if ({load_done, cpu_clr, cap.size() == 0} !== {exp_done, !exp_done, 1'b1}) begin
      bad++; $display("FAIL ignore33: done=%b clr=%b writes=%0d required %b %b 0",
                      load_done, cpu_clr, cap.size(), exp_done, !exp_done);
    end
    build_frame(2, 1);
    send_byte(tx[0], 0);
    total++;
    if ({load_done, load_err, cpu_clr} !== 3'b001) begin
      bad++; $display("FAIL reload_hdr: done=%b err=%b clr=%b required 0 0 1", load_done, load_err, cpu_clr);
    end
    tx.pop_front();
    play(1);
    total++;
    if (cap.size() != 2 || cap[0] !== exp_w[0] || cap[1] !== exp_w[1] || load_done !== exp_done) begin
      bad++; $display("FAIL reload_frame: writes=%0d done=%b required 2 %b", cap.size(), load_done, exp_done);
    end
  endtask

  task automatic test_random_gaps();
    for (int f = 0; f < 8; f++) begin
      int n;
      n = (f == 5) ? 0 : $urandom_range(1, 8);
      build_frame(n, $urandom_range(0, 3) != 0);
      play(1);
      total++;
      if (cap.size() != exp_w.size()) begin
        bad++; $display("FAIL rand%0d_nwrites: got %0d required %0d", f, cap.size(), exp_w.size());
      end else begin
        foreach (cap[i]) begin
          total++;
          if (cap[i] !== exp_w[i]) begin
            bad++; $display("FAIL rand%0d_write%0d: got %h required %h", f, i, cap[i], exp_w[i]);
          end
        end
      end
      total++;
      if ({load_done, load_err, cpu_clr, words_loaded} !== {exp_done, exp_err, !exp_done, 7'(exp_wl)}) begin
        bad++;
        $display("FAIL rand%0d_flags: done=%b err=%b clr=%b wl=%0d required %b %b %b %0d", f,
                 load_done, load_err, cpu_clr, words_loaded, exp_done, exp_err, !exp_done, exp_wl);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    build_frame(2, 1);
    while (tx.size() > 7) void'(tx.pop_back());
    play(0);
    clr_n = 1'b0;
    #1;
    total++;
    if (cap.size() != 1 || cap[0] !== exp_w[0]) begin
      bad++; $display("FAIL midrst_writes: got %0d writes required 1 (%h)", cap.size(), exp_w[0]);
    end
    total++;
    if ({byte_ready, cpu_clr, imu_wen, load_done, load_err, words_loaded} !== {5'b11000, 7'd0}) begin
      bad++; $display("FAIL midrst_state: rdy=%b clr=%b wen=%b done=%b err=%b wl=%0d required 1 1 0 0 0 0",
                      byte_ready, cpu_clr, imu_wen, load_done, load_err, words_loaded);
    end
    @(negedge clk);
    clr_n = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (cap.size() != 1) begin
      bad++; $display("FAIL midrst_nomore: got %0d writes required 1", cap.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_count_limits();
    test_idle_ignore_and_reload();
    test_random_gaps();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
